// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Results are split into HI/LO with a start/busy/done handshake to the control unit.
module mult_div_unit #(
    parameter int OPERAND_WIDTH = 32,
    parameter int CNT_WIDTH     = $clog2(OPERAND_WIDTH) + 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [OPERAND_WIDTH-1:0] Operand1,
    input  logic [OPERAND_WIDTH-1:0] Operand2,
    input  logic                     Signed_Op,
    input  logic                     mult_start,
    input  logic                     div_start,
    output logic [OPERAND_WIDTH-1:0] HI_OUT,
    output logic [OPERAND_WIDTH-1:0] LO_OUT,
    output logic                     Busy,
    output logic                     mult_div_done,
    output logic                     DZ_OUT,
    output logic                     OF_OUT
);

    localparam int W = OPERAND_WIDTH;
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t               state;
    state_t               state_next;
    logic [2*W-1:0]       acc;
    logic [W-1:0]         addend;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 neg_lo;
    logic                 neg_hi;
    logic                 dz_flag;
    logic                 of_flag;

    logic                 sign1;
    logic                 sign2;
    logic [W-1:0]         mag1;
    logic [W-1:0]         mag2;
    logic                 last_iter;
    logic [W:0]           mult_sum;
    logic [W:0]           div_shift;
    logic [W:0]           div_diff;
    logic [2*W-1:0]       mult_next;
    logic [2*W-1:0]       div_next;
    logic [2*W-1:0]       prod_res;
    logic [W-1:0]         quo_res;
    logic [W-1:0]         rem_res;

    assign sign1     = Signed_Op & Operand1[W-1];
    assign sign2     = Signed_Op & Operand2[W-1];
    assign mag1      = sign1 ? -Operand1 : Operand1;
    assign mag2      = sign2 ? -Operand2 : Operand2;
    assign last_iter = (cnt == CNT_WIDTH'(W));

    // acc holds {partial product, multiplier} while multiplying and
    // {remainder, dividend/quotient} while dividing
    assign mult_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, addend} : '0);
    assign mult_next = {mult_sum, acc[W-1:1]};
    assign div_shift = acc[2*W-1:W-1];
    assign div_diff  = div_shift - {1'b0, addend};
    assign div_next  = div_diff[W] ? {div_shift[W-1:0], acc[W-2:0], 1'b0}
                                   : {div_diff[W-1:0],  acc[W-2:0], 1'b1};

    assign prod_res  = neg_lo ? -acc : acc;
    assign quo_res   = neg_lo ? -acc[W-1:0] : acc[W-1:0];
    assign rem_res   = neg_hi ? -acc[2*W-1:W] : acc[2*W-1:W];

    assign Busy          = (state != IDLE);
    assign mult_div_done = (state == DONE);

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (mult_start)     state_next = MULT;
                else if (div_start) state_next = DIV;
            end
            MULT: if (last_iter)            state_next = DONE;
            DIV:  if (dz_flag || last_iter) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc     <= '0;
            addend  <= '0;
            cnt     <= '0;
            neg_lo  <= 1'b0;
            neg_hi  <= 1'b0;
            dz_flag <= 1'b0;
            of_flag <= 1'b0;
            HI_OUT  <= '0;
            LO_OUT  <= '0;
            DZ_OUT  <= 1'b0;
            OF_OUT  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mult_start) begin
                        acc     <= {{W{1'b0}}, mag2};
                        addend  <= mag1;
                        cnt     <= '0;
                        neg_lo  <= sign1 ^ sign2;
                        neg_hi  <= sign1 ^ sign2;
                        dz_flag <= 1'b0;
                        of_flag <= 1'b0;
                    end else if (div_start) begin
                        // a zero divisor parks the raw dividend and all-ones quotient in acc
                        acc     <= (Operand2 == '0) ? {Operand1, {W{1'b1}}}
                                                    : {{W{1'b0}}, mag1};
                        addend  <= mag2;
                        cnt     <= '0;
                        neg_lo  <= sign1 ^ sign2;
                        neg_hi  <= sign1;
                        dz_flag <= (Operand2 == '0);
                        of_flag <= Signed_Op && (Operand1 == MIN_VAL) && (Operand2 == {W{1'b1}});
                    end
                end
                MULT: begin
                    if (last_iter) begin
                        HI_OUT <= prod_res[2*W-1:W];
                        LO_OUT <= prod_res[W-1:0];
                        DZ_OUT <= 1'b0;
                        OF_OUT <= 1'b0;
                    end else begin
                        acc <= mult_next;
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                DIV: begin
                    if (dz_flag) begin
                        HI_OUT <= acc[2*W-1:W];
                        LO_OUT <= acc[W-1:0];
                        DZ_OUT <= 1'b1;
                        OF_OUT <= 1'b0;
                    end else if (last_iter) begin
                        HI_OUT <= rem_res;
                        LO_OUT <= quo_res;
                        DZ_OUT <= 1'b0;
                        OF_OUT <= of_flag;
                    end else begin
                        acc <= div_next;
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vectors with literal expectations plus
// an arithmetic reference model compared against the DUT every cycle.
module tb_mult_div_unit;

    localparam int W = 32;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [W-1:0]  Operand1 = '0;
    logic [W-1:0]  Operand2 = '0;
    logic          Signed_Op = 1'b0;
    logic          mult_start = 1'b0;
    logic          div_start = 1'b0;
    logic [W-1:0]  HI_OUT;
    logic [W-1:0]  LO_OUT;
    logic          Busy;
    logic          mult_div_done;
    logic          DZ_OUT;
    logic          OF_OUT;

    int tests_run = 0;
    int tests_failed = 0;
    logic chk_en = 1'b0;

    // reference model state: visible outputs plus the pending result and its countdown
    logic          m_busy = 1'b0;
    logic          m_done = 1'b0;
    logic [W-1:0]  m_hi = '0;
    logic [W-1:0]  m_lo = '0;
    logic          m_dz = 1'b0;
    logic          m_of = 1'b0;
    logic [W-1:0]  p_hi = '0;
    logic [W-1:0]  p_lo = '0;
    logic          p_dz = 1'b0;
    logic          p_of = 1'b0;
    int            m_cnt = 0;

    mult_div_unit #(.OPERAND_WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .Operand1(Operand1), .Operand2(Operand2),
        .Signed_Op(Signed_Op), .mult_start(mult_start), .div_start(div_start),
        .HI_OUT(HI_OUT), .LO_OUT(LO_OUT), .Busy(Busy), .mult_div_done(mult_div_done),
        .DZ_OUT(DZ_OUT), .OF_OUT(OF_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // plain-arithmetic result of one operation
    function automatic void modelOp(input logic m, input logic s, input logic [W-1:0] a,
                                    input logic [W-1:0] b, output logic [W-1:0] hi,
                                    output logic [W-1:0] lo, output logic dz, output logic of);
        logic [63:0] pu;
        logic signed [63:0] ps;
        int ia, ib;
        dz = 1'b0;
        of = 1'b0;
        if (m) begin
            if (s) begin
                ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                pu = ps;
            end else begin
                pu = {32'b0, a} * {32'b0, b};
            end
            hi = pu[63:32];
            lo = pu[31:0];
        end else if (b == 0) begin
            hi = a;
            lo = '1;
            dz = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            hi = '0;
            lo = a;
            of = 1'b1;
        end else if (s) begin
            ia = a;
            ib = b;
            lo = ia / ib;
            hi = ia % ib;
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    // compare against the model, then advance the model to the next rising edge
    always @(negedge CLK) begin
        if (chk_en) begin
            checkVal("busy", Busy, m_busy);
            checkVal("done", mult_div_done, m_done);
            checkVal("hi", HI_OUT, m_hi);
            checkVal("lo", LO_OUT, m_lo);
            checkVal("dz", DZ_OUT, m_dz);
            checkVal("of", OF_OUT, m_of);
        end
        if (RST) begin
            m_busy = 0; m_done = 0; m_hi = 0; m_lo = 0; m_dz = 0; m_of = 0; m_cnt = 0;
        end else if (!m_busy) begin
            if (mult_start || div_start) begin
                modelOp(mult_start, Signed_Op, Operand1, Operand2, p_hi, p_lo, p_dz, p_of);
                m_cnt  = (!mult_start && Operand2 == 0) ? 1 : W + 1;
                m_busy = 1;
            end
        end else if (m_done) begin
            m_busy = 0;
            m_done = 0;
        end else begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_hi = p_hi; m_lo = p_lo; m_dz = p_dz; m_of = p_of;
                m_done = 1;
            end
        end
    end

    // issue one start, scramble operands afterwards, optionally re-start or reset mid-operation
    task automatic applyStimulus(input logic m, input logic d, input logic s,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int restart_at, input int reset_at,
                                 output int lat, output int busy_cyc, output int done_cnt,
                                 output logic ended);
        @(posedge CLK); #2;
        Operand1 = a; Operand2 = b; Signed_Op = s; mult_start = m; div_start = d;
        @(posedge CLK); #2;
        mult_start = 0; div_start = 0;
        Operand1 = $urandom; Operand2 = $urandom; Signed_Op = 1'($urandom_range(0, 1));
        lat = -1; busy_cyc = 0; done_cnt = 0; ended = 0;
        for (int j = 1; j <= 80; j++) begin
            @(negedge CLK);
            if (Busy) busy_cyc++;
            if (mult_div_done) begin
                done_cnt++;
                if (lat < 0) lat = j - 1;
            end
            if (!Busy) begin
                ended = 1;
                break;
            end
            @(posedge CLK); #2;
            mult_start = (j == restart_at);
            div_start  = (j == restart_at);
            RST        = (j == reset_at);
        end
    endtask

    task automatic checkOutput(input string name, input logic m, input logic d, input logic s,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input int restart_at, input int reset_at,
                               input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                               input logic e_dz, input logic e_of, input int e_lat,
                               input int e_busy, input int e_done);
        int lat, busy_cyc, done_cnt;
        logic ended;
        applyStimulus(m, d, s, a, b, restart_at, reset_at, lat, busy_cyc, done_cnt, ended);
        checkVal({name, " finished"}, ended, 1'b1);
        checkVal({name, " hi"}, HI_OUT, e_hi);
        checkVal({name, " lo"}, LO_OUT, e_lo);
        checkVal({name, " dz"}, DZ_OUT, e_dz);
        checkVal({name, " of"}, OF_OUT, e_of);
        checkVal({name, " latency"}, lat, e_lat);
        checkVal({name, " busy cycles"}, busy_cyc, e_busy);
        checkVal({name, " done pulses"}, done_cnt, e_done);
        @(posedge CLK); #2;
        RST = 0; mult_start = 0; div_start = 0;
    endtask

    initial begin
        RST = 1;
        @(posedge CLK); #2;
        chk_en = 1;
        @(posedge CLK); #2;
        @(posedge CLK); #2;
        RST = 0;

        checkOutput("umul max", 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0,
                    32'hFFFF_FFFE, 32'h0000_0001, 0, 0, 33, 34, 1);
        checkOutput("smul -7*3", 1, 0, 1, 32'hFFFF_FFF9, 32'd3, 0, 0,
                    32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0, 33, 34, 1);
        checkOutput("sdiv -7/2", 0, 1, 1, 32'hFFFF_FFF9, 32'd2, 0, 0,
                    32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, 33, 34, 1);
        checkOutput("udiv 100/7", 0, 1, 0, 32'd100, 32'd7, 0, 0,
                    32'd2, 32'd14, 0, 0, 33, 34, 1);
        checkOutput("div by zero", 0, 1, 0, 32'h1234, 32'd0, 0, 0,
                    32'h1234, 32'hFFFF_FFFF, 1, 0, 1, 2, 1);
        checkOutput("sdiv overflow", 0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0,
                    32'd0, 32'h8000_0000, 0, 1, 33, 34, 1);
        checkOutput("both starts", 1, 1, 0, 32'd6, 32'd7, 0, 0,
                    32'd0, 32'd42, 0, 0, 33, 34, 1);
        checkOutput("restart mid-op", 1, 0, 0, 32'h0001_0000, 32'h0001_0000, 10, 0,
                    32'd1, 32'd0, 0, 0, 33, 34, 1);
        checkOutput("start in DONE", 0, 1, 0, 32'd1000, 32'd10, 33, 0,
                    32'd0, 32'd100, 0, 0, 33, 34, 1);
        checkOutput("reset mid-div", 0, 1, 0, 32'd100, 32'd7, 0, 15,
                    32'd0, 32'd0, 0, 0, -1, 16, 0);
        checkOutput("smul after reset", 1, 0, 1, 32'd12345, 32'hFFFF_FFFE, 0, 0,
                    32'hFFFF_FFFF, 32'hFFFF_9F8E, 0, 0, 33, 34, 1);
        checkOutput("sdiv -100/-7", 0, 1, 1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 0, 0,
                    32'hFFFF_FFFE, 32'd14, 0, 0, 33, 34, 1);
        checkOutput("sdiv 7/-2", 0, 1, 1, 32'd7, 32'hFFFF_FFFE, 0, 0,
                    32'd1, 32'hFFFF_FFFD, 0, 0, 33, 34, 1);
        checkOutput("udiv max/1", 0, 1, 0, 32'hFFFF_FFFF, 32'd1, 0, 0,
                    32'd0, 32'hFFFF_FFFF, 0, 0, 33, 34, 1);
        checkOutput("udiv msb set", 0, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0,
                    32'h8000_0000, 32'd0, 0, 0, 33, 34, 1);
        checkOutput("smul min*min", 1, 0, 1, 32'h8000_0000, 32'h8000_0000, 0, 0,
                    32'h4000_0000, 32'd0, 0, 0, 33, 34, 1);

        @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multi-cycle multiply/divide unit for the multi-cycle MIPS datapath.
- Provides the MULT/MULTU/DIV/DIVU results that the combinational ALU cannot produce in one cycle.
- Generalised in operand width and signed/unsigned mode.
- Produces a 2*OPERAND_WIDTH result split into HI and LO, with a start/busy/done handshake to the control unit.

Parameters:
- OPERAND_WIDTH, 32, width W of each operand, HI_OUT and LO_OUT; any even value >= 4.
- CNT_WIDTH, $clog2(OPERAND_WIDTH)+1, iteration counter width.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous active-high reset.
- Operand1  input  W  multiplicand / dividend; sampled only on an accepted start.
- Operand2  input  W  multiplier / divisor; sampled only on an accepted start.
- Signed_Op  input  1  1 = two's-complement operation, 0 = unsigned; sampled with the operands.
- mult_start  input  1  request a multiply.
- div_start  input  1  request a divide.
- HI_OUT  output  W  product upper half / remainder.
- LO_OUT  output  W  product lower half / quotient.
- Busy  output  1  high while an operation is in progress (not IDLE).
- mult_div_done  output  1  single-cycle pulse when HI_OUT/LO_OUT are updated.
- DZ_OUT  output  1  divide-by-zero flag for the last operation.
- OF_OUT  output  1  signed divide overflow (MIN / -1) for the last operation.

Behaviour:
- Clock and reset: one clock, CLK; reset RST is synchronous, active-high.
- Reset:
  - The state machine goes to IDLE.
  - HI_OUT, LO_OUT, DZ_OUT, OF_OUT, mult_div_done and Busy are all 0.
  - Internal accumulators and the counter are cleared.
  - Reset asserted mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, MULT, DIV, DONE.
- IDLE:
  - Start is accepted on edge k if mult_start or div_start is high.
  - If both are high, mult_start wins.
  - On acceptance:
    - latch operand magnitudes: absolute values when Signed_Op=1, raw values otherwise;
    - latch the result-sign bits (product sign = sign1 XOR sign2; remainder sign = sign1);
    - clear the counter;
    - go to MULT or DIV.
- Divide-by-zero (div_start accepted, Operand2 = 0):
  - Skip DIV and go directly to DONE at edge k+1.
  - HI_OUT = Operand1 (raw), LO_OUT = all ones, DZ_OUT = 1, OF_OUT = 0.
- MULT:
  - Shift-add, one multiplier bit per cycle.
  - Edges k+1..k+W perform exactly W iterations; then go to DONE.
- DIV:
  - Restoring division, one quotient bit per cycle.
  - Edges k+1..k+W perform exactly W iterations; then go to DONE.
- Result write-back (transition into DONE, edge k+W+1 normally, k+1 for divide-by-zero):
  - HI_OUT/LO_OUT are written with sign-corrected results:
    - product is negated as a 2W-bit value if the product sign is 1;
    - quotient is negated if sign1 XOR sign2;
    - remainder is negated if sign1.
  - DZ_OUT/OF_OUT are written.
  - mult_div_done = 1 for the cycle following that edge only.
- DONE: lasts one cycle, then returns to IDLE unconditionally.
  - A start seen while in DONE is ignored; a new start is accepted only in IDLE.
- Busy:
  - Busy = 1 in MULT, DIV and DONE.
  - mult_start/div_start are ignored while Busy = 1 (no queuing).
- Latency: W+1 cycles from the accepting edge to the done pulse (divide-by-zero: 1 cycle). Throughput: one operation per W+3 cycles max.
- Result hold: HI_OUT/LO_OUT/DZ_OUT/OF_OUT hold their values until the next write-back; they do not change during an operation.
- Signed overflow (Signed_Op=1, Operand1 = MIN, Operand2 = -1):
  - LO_OUT = MIN, HI_OUT = 0, OF_OUT = 1.
  - Magnitude 2^(W-1) must be representable in the unsigned datapath.
- Unsigned mode: DZ_OUT and OF_OUT are never set except DZ_OUT on a zero divisor.
- Operand changes after acceptance have no effect on the result.

Test Plan:
- W=32, Signed_Op=0, mult_start, Operand1=0xFFFFFFFF, Operand2=0xFFFFFFFF -> done exactly 33 cycles after accept; HI_OUT=0xFFFFFFFE, LO_OUT=0x00000001; Busy high for 34 cycles.
- Signed_Op=1, mult_start, Operand1=-7 (0xFFFFFFF9), Operand2=3 -> HI_OUT=0xFFFFFFFF, LO_OUT=0xFFFFFFEB (-21).
- Signed_Op=1, div_start, Operand1=-7, Operand2=2 -> LO_OUT=0xFFFFFFFD (-3), HI_OUT=0xFFFFFFFF (-1), DZ_OUT=0, OF_OUT=0; with Signed_Op=0, 100/7 -> LO_OUT=14, HI_OUT=2.
- div_start, Operand2=0, Operand1=0x1234 -> done 1 cycle after accept; DZ_OUT=1, HI_OUT=0x1234, LO_OUT=0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF -> LO_OUT=0x80000000, HI_OUT=0, OF_OUT=1.
- mult_start and div_start high together -> multiply performed. A second start pulse at cycle 10 of an operation -> ignored; results unchanged; exactly one done pulse.
- RST asserted at cycle 15 of a divide -> next cycle Busy=0, all outputs 0, no done pulse. A new start accepted 1 cycle after RST drops completes correctly.
